spi_prog_loader: RTL and testbench

Controller that sequences program download from the SPI slave into CPU instruction memory. It parses each SPI frame as a length header, a run of program words and, optionally, a checksum trailer. It generates the instruction-memory write address, data and strobe. It holds the CPU in reset from power-up until a frame has loaded cleanly, so a truncated or corrupt image never executes. It sits between `spi` and `cpu_top`, replacing the free-running write-address counter and the raw chip-select reset.

---
 rtl/spi_prog_loader.sv | 165 ++++++++++++++++
 tb/tb_spi_prog_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_prog_loader.sv
// rtl/spi_prog_loader.sv - SPI frame parser that loads CPU instruction memory and gates CPU reset.
// Optional checksum trailer enabled by defining SPI_PROG_LOADER_CHECKSUM_EN.
module spi_prog_loader #(
    parameter int IADDR_WIDTH = 8,
    parameter int WIDTH       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   new_transfer,
    input  logic                   chip_selected,
    input  logic                   word_valid,
    input  logic [WIDTH-1:0]       word,
    output logic [IADDR_WIDTH-1:0] iaddr_write,
    output logic [WIDTH-1:0]       idata_write,
    output logic                   i_write,
    output logic                   cpu_reset,
    output logic                   load_busy,
    output logic [1:0]             load_err
);

    typedef enum logic [2:0] {EMPTY, HEADER, DATA, CHECK, TAIL, RUN, ERROR} state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_LEN   = 2'd1;
    localparam logic [1:0] ERR_FRAME = 2'd2;
`ifdef SPI_PROG_LOADER_CHECKSUM_EN
    localparam logic [1:0] ERR_SUM   = 2'd3;
`endif
    localparam logic [WIDTH:0] MAX_LEN = (WIDTH+1)'(1) << IADDR_WIDTH;

    state_t                 state_q, state_d;
    logic [1:0]             err_q, err_d;
    // One bit wider than the address so a full 2^IADDR_WIDTH image counts without wrapping.
    logic [IADDR_WIDTH:0]   cnt_q, len_q;
    logic [IADDR_WIDTH-1:0] iaddr_q;
    logic [WIDTH-1:0]       idata_q;
    logic                   i_write_q, cpu_reset_q, busy_q;
    logic                   hdr_bad, last_word;
`ifdef SPI_PROG_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0]       sum_q;
`endif

    assign hdr_bad   = (word == '0) || ({1'b0, word} > MAX_LEN);
    assign last_word = (cnt_q + (IADDR_WIDTH+1)'(1)) == len_q;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        if (new_transfer) begin
            state_d = HEADER;
            err_d   = ERR_NONE;
        end else begin
            case (state_q)
                HEADER: begin
                    if (word_valid) begin
                        if (hdr_bad) begin
                            state_d = ERROR;
                            err_d   = ERR_LEN;
                        end else if (!chip_selected) begin
                            state_d = ERROR;
                            err_d   = ERR_FRAME;
                        end else begin
                            state_d = DATA;
                        end
                    end else if (!chip_selected) begin
                        state_d = ERROR;
                        err_d   = ERR_FRAME;
                    end
                end
                DATA: begin
                    if (word_valid && last_word) begin
`ifdef SPI_PROG_LOADER_CHECKSUM_EN
                        if (chip_selected) begin
                            state_d = CHECK;
                        end else begin
                            state_d = ERROR;
                            err_d   = ERR_FRAME;
                        end
`else
                        state_d = chip_selected ? TAIL : RUN;
`endif
                    end else if (!chip_selected) begin
                        state_d = ERROR;
                        err_d   = ERR_FRAME;
                    end
                end
`ifdef SPI_PROG_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (word_valid) begin
                        if (word != sum_q) begin
                            state_d = ERROR;
                            err_d   = ERR_SUM;
                        end else begin
                            state_d = chip_selected ? TAIL : RUN;
                        end
                    end else if (!chip_selected) begin
                        state_d = ERROR;
                        err_d   = ERR_FRAME;
                    end
                end
`endif
                TAIL: begin
                    if (word_valid && chip_selected) begin
                        state_d = ERROR;
                        err_d   = ERR_FRAME;
                    end else if (!chip_selected) begin
                        state_d = RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            err_q       <= ERR_NONE;
            cnt_q       <= '0;
            len_q       <= '0;
            iaddr_q     <= '0;
            idata_q     <= '0;
            i_write_q   <= 1'b0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
`ifdef SPI_PROG_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            cpu_reset_q <= (state_d != RUN);
            busy_q      <= (state_d inside {HEADER, DATA, CHECK, TAIL});
            i_write_q   <= 1'b0;
            if (new_transfer) begin
                cnt_q <= '0;
`ifdef SPI_PROG_LOADER_CHECKSUM_EN
                sum_q <= '0;
`endif
            end else if (word_valid) begin
                if (state_q == HEADER && !hdr_bad) begin
                    len_q <= (IADDR_WIDTH+1)'(word);
                    cnt_q <= '0;
                end
                if (state_q == DATA) begin
                    i_write_q <= 1'b1;
                    iaddr_q   <= cnt_q[IADDR_WIDTH-1:0];
                    idata_q   <= word;
                    cnt_q     <= cnt_q + (IADDR_WIDTH+1)'(1);
`ifdef SPI_PROG_LOADER_CHECKSUM_EN
                    sum_q     <= sum_q + word;
`endif
                end
            end
        end
    end

    assign iaddr_write = iaddr_q;
    assign idata_write = idata_q;
    assign i_write     = i_write_q;
    assign cpu_reset   = cpu_reset_q;
    assign load_busy   = busy_q;
    assign load_err    = err_q;

endmodule

// File: tb/tb_spi_prog_loader.sv
// tb/tb_spi_prog_loader.sv - directed self-checking bench for spi_prog_loader.
module tb_spi_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        new_transfer = 1'b0;
    logic        chip_selected = 1'b0;
    logic        word_valid = 1'b0;
    logic [15:0] word = '0;
    logic [7:0]  iaddr_write;
    logic [15:0] idata_write;
    logic        i_write;
    logic        cpu_reset;
    logic        load_busy;
    logic [1:0]  load_err;

    int errors = 0;
    int checks = 0;
    logic [7:0]  wa[$];
    logic [15:0] wd[$];

    spi_prog_loader #(.IADDR_WIDTH(8), .WIDTH(16)) dut (
        .clk(clk), .reset(reset), .new_transfer(new_transfer),
        .chip_selected(chip_selected), .word_valid(word_valid), .word(word),
        .iaddr_write(iaddr_write), .idata_write(idata_write), .i_write(i_write),
        .cpu_reset(cpu_reset), .load_busy(load_busy), .load_err(load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (i_write === 1'b1) begin
            wa.push_back(iaddr_write);
            wd.push_back(idata_write);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        chip_selected = 1'b1;
        new_transfer  = 1'b1;
        tick();
        new_transfer  = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        word       = w;
        word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
    endtask

    task automatic deselect();
        chip_selected = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_cpu_reset got %b exp 1", cpu_reset); end
        checks++; if (load_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", load_busy); end
        checks++; if (load_err !== 2'd0) begin errors++; $display("FAIL reset_err got %0d exp 0", load_err); end
        checks++; if ({iaddr_write, idata_write, i_write} !== 25'd0) begin errors++;
            $display("FAIL reset_mem_if got %h/%h/%b exp 0/0/0", iaddr_write, idata_write, i_write); end
        reset = 1'b1;
        tick();
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL empty_cpu_reset got %b exp 1", cpu_reset); end
    endtask

    task automatic test_good_frame();
        wa.delete(); wd.delete();
        start_frame();
        checks++; if (load_busy !== 1'b1) begin errors++; $display("FAIL good_busy_hdr got %b exp 1", load_busy); end
        send_word(16'd3);
        send_word(16'h0001);
        checks++; if (i_write !== 1'b1) begin errors++; $display("FAIL good_strobe got %b exp 1", i_write); end
        send_word(16'h0002);
        send_word(16'h0003);
`ifdef SPI_PROG_LOADER_CHECKSUM_EN
        send_word(16'h0006);
`endif
        checks++; if (cpu_reset !== 1'b1 || load_busy !== 1'b1) begin errors++;
            $display("FAIL good_tail got rst=%b busy=%b exp 1/1", cpu_reset, load_busy); end
        deselect();
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL good_run got cpu_reset=%b exp 0", cpu_reset); end
        checks++; if (load_err !== 2'd0 || load_busy !== 1'b0) begin errors++;
            $display("FAIL good_status got err=%0d busy=%b exp 0/0", load_err, load_busy); end
        checks++; if (wa.size() !== 3) begin errors++; $display("FAIL good_nwrites got %0d exp 3", wa.size()); end
        else for (int i = 0; i < 3; i++) begin
            checks++;
            if (wa[i] !== 8'(i) || wd[i] !== 16'(i + 1)) begin errors++;
                $display("FAIL good_write%0d got %h:%h exp %h:%h", i, wa[i], wd[i], 8'(i), 16'(i + 1)); end
        end
    endtask

`ifdef SPI_PROG_LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        wa.delete(); wd.delete();
        start_frame();
        send_word(16'd3);
        send_word(16'h0001);
        send_word(16'h0002);
        send_word(16'h0003);
        send_word(16'h0007);
        checks++; if (load_err !== 2'd3) begin errors++; $display("FAIL badsum_err got %0d exp 3", load_err); end
        deselect();
        checks++; if (cpu_reset !== 1'b1 || load_busy !== 1'b0) begin errors++;
            $display("FAIL badsum_state got rst=%b busy=%b exp 1/0", cpu_reset, load_busy); end
        checks++; if (wa.size() !== 3) begin errors++; $display("FAIL badsum_nwrites got %0d exp 3", wa.size()); end
    endtask
`endif

    task automatic test_bad_length();
        logic [15:0] hdr [2];
        hdr[0] = 16'd0;
        hdr[1] = 16'd257;
        for (int k = 0; k < 2; k++) begin
            wa.delete(); wd.delete();
            start_frame();
            send_word(hdr[k]);
            checks++; if (load_err !== 2'd1) begin errors++; $display("FAIL badlen%0d_err got %0d exp 1", k, load_err); end
            send_word(16'h1111);
            deselect();
            checks++; if (wa.size() !== 0 || cpu_reset !== 1'b1 || load_busy !== 1'b0) begin errors++;
                $display("FAIL badlen%0d_state got writes=%0d rst=%b busy=%b exp 0/1/0", k, wa.size(), cpu_reset, load_busy); end
        end
    endtask

    task automatic test_max_length();
        logic [15:0] sum = '0;
        int bad = 0;
        wa.delete(); wd.delete();
        start_frame();
        send_word(16'd256);
        for (int i = 0; i < 256; i++) begin
            send_word(16'(i) ^ 16'hA5A5);
            sum = sum + (16'(i) ^ 16'hA5A5);
            if (i == 254) begin
                checks++; if (load_busy !== 1'b1 || load_err !== 2'd0) begin errors++;
                    $display("FAIL maxlen_midway got busy=%b err=%0d exp 1/0", load_busy, load_err); end
            end
        end
`ifdef SPI_PROG_LOADER_CHECKSUM_EN
        send_word(sum);
`endif
        deselect();
        checks++; if (cpu_reset !== 1'b0 || load_err !== 2'd0) begin errors++;
            $display("FAIL maxlen_run got rst=%b err=%0d exp 0/0", cpu_reset, load_err); end
        checks++; if (wa.size() !== 256) begin errors++; $display("FAIL maxlen_nwrites got %0d exp 256", wa.size()); end
        else begin
            for (int i = 0; i < 256; i++)
                if (wa[i] !== 8'(i) || wd[i] !== (16'(i) ^ 16'hA5A5)) bad++;
            checks++; if (bad !== 0) begin errors++; $display("FAIL maxlen_writes got %0d bad writes exp 0", bad); end
        end
    endtask

    task automatic test_truncation();
        start_frame();
        send_word(16'd4);
        send_word(16'h0010);
        send_word(16'h0020);
        deselect();
        checks++; if (load_err !== 2'd2 || cpu_reset !== 1'b1) begin errors++;
            $display("FAIL trunc got err=%0d rst=%b exp 2/1", load_err, cpu_reset); end
        start_frame();
        checks++; if (load_err !== 2'd0 || load_busy !== 1'b1) begin errors++;
            $display("FAIL trunc_clear got err=%0d busy=%b exp 0/1", load_err, load_busy); end
        send_word(16'd1);
        send_word(16'h0042);
`ifdef SPI_PROG_LOADER_CHECKSUM_EN
        send_word(16'h0042);
`endif
        deselect();
        checks++; if (cpu_reset !== 1'b0 || load_err !== 2'd0) begin errors++;
            $display("FAIL trunc_recover got rst=%b err=%0d exp 0/0", cpu_reset, load_err); end
    endtask

    task automatic test_overrun();
        start_frame();
        send_word(16'd1);
        send_word(16'h0055);
`ifdef SPI_PROG_LOADER_CHECKSUM_EN
        send_word(16'h0055);
`endif
        send_word(16'h0066);
        checks++; if (load_err !== 2'd2) begin errors++; $display("FAIL overrun_err got %0d exp 2", load_err); end
        deselect();
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL overrun_rst got %b exp 1", cpu_reset); end
    endtask

    task automatic test_collision();
        wa.delete(); wd.delete();
        start_frame();
        send_word(16'd2);
        new_transfer = 1'b1;
        send_word(16'h0000);
        new_transfer = 1'b0;
        checks++; if (load_busy !== 1'b1 || load_err !== 2'd0) begin errors++;
            $display("FAIL collide_hdr got busy=%b err=%0d exp 1/0", load_busy, load_err); end
        tick();
        checks++; if (wa.size() !== 0) begin errors++; $display("FAIL collide_nowrite got %0d exp 0", wa.size()); end
        send_word(16'd1);
        chip_selected = 1'b0;
`ifdef SPI_PROG_LOADER_CHECKSUM_EN
        chip_selected = 1'b1;
        send_word(16'h1234);
        chip_selected = 1'b0;
        send_word(16'h1234);
`else
        send_word(16'h1234);
`endif
        checks++; if (cpu_reset !== 1'b0 || load_err !== 2'd0) begin errors++;
            $display("FAIL collide_lastdesel got rst=%b err=%0d exp 0/0", cpu_reset, load_err); end
        tick();
        checks++; if (wa.size() !== 1 || wa[0] !== 8'h00 || wd[0] !== 16'h1234) begin errors++;
            $display("FAIL collide_write got n=%0d exp 1 write 00:1234", wa.size()); end
    endtask

    task automatic test_async_reset();
        wa.delete(); wd.delete();
        start_frame();
        send_word(16'd4);
        send_word(16'h00A1);
        send_word(16'h00A2);
        checks++; if (i_write !== 1'b1) begin errors++; $display("FAIL arst_pre got i_write=%b exp 1", i_write); end
        reset = 1'b0;
        #1;
        checks++; if ({iaddr_write, idata_write, i_write, load_busy, load_err} !== 28'd0 || cpu_reset !== 1'b1) begin errors++;
            $display("FAIL arst_now got a=%h d=%h w=%b busy=%b err=%0d rst=%b exp 0/0/0/0/0/1",
                     iaddr_write, idata_write, i_write, load_busy, load_err, cpu_reset); end
        tick();
        reset = 1'b1;
        deselect();
        wa.delete(); wd.delete();
        start_frame();
        send_word(16'd1);
        send_word(16'h00AA);
        tick();
        checks++; if (wa.size() !== 1 || wa[0] !== 8'h00 || wd[0] !== 16'h00AA) begin errors++;
            $display("FAIL arst_reload got n=%0d exp 1 write 00:00aa", wa.size()); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
`ifdef SPI_PROG_LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_bad_length();
        test_max_length();
        test_truncation();
        test_overrun();
        test_collision();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
